// File: rtl/wimax_pkg.sv
// Shared 802.16 interleaver constants, index type and the deinterleave address map.
// deint_addr is evaluated only at elaboration, so its divides never reach hardware.
package wimax_pkg;

    localparam int NCBPS_QPSK = 192;
    localparam int D_WIMAX    = 16;

    typedef logic [$clog2(NCBPS_QPSK)-1:0] bit_idx_t;

    // Received index j lands at FEC-order address k(j).
    function automatic int deint_addr(input int j, input int ncbps, input int s, input int d);
        int q;
        int m;
        q = (j * d) / ncbps;
        m = s * (j / s) + ((j + q) % s);
        return d * m - (ncbps - 1) * ((m * d) / ncbps);
    endfunction

endpackage

// File: rtl/deint_pingpong_buf.sv
// Two-bank bit buffer for the deinterleaver: one random-address write port,
// one sequential-address read port (combinational read, contents never reset).
module deint_pingpong_buf #(
    parameter int NCBPS = 192,
    parameter int AW    = $clog2(NCBPS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          wbank_i,
    input  logic [AW-1:0] waddr_i,
    input  logic          wdata_i,
    input  logic          rbank_i,
    input  logic [AW-1:0] raddr_i,
    output logic          rdata_o
);

    logic [NCBPS-1:0] bank_q [2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            bank_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = bank_q[rbank_i][raddr_i];

endmodule

// File: rtl/deinterleaver_top.sv
// 802.16 receive deinterleaver: bits are scattered into a ping-pong bank by a
// constant address table and read back in order. DEINT_SOB_EN adds sob_out/blk_cnt.
module deinterleaver_top
    import wimax_pkg::*;
#(
    parameter int NCBPS = NCBPS_QPSK,
    parameter int NCPC  = 2,
    parameter int D     = D_WIMAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        data_out,
    output logic        valid_out,
`ifdef DEINT_SOB_EN
    output logic        sob_out,
    output logic [15:0] blk_cnt,
`endif
    input  logic        ready_in
);

    localparam int S  = (NCPC / 2 > 1) ? NCPC / 2 : 1;
    localparam int AW = $clog2(NCBPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NCBPS - 1);

    logic [AW-1:0] addr_tbl [NCBPS];

    for (genvar g = 0; g < NCBPS; g++) begin : g_addr
        assign addr_tbl[g] = AW'(deint_addr(g, NCBPS, S, D));
    end

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          wr_xfer, rd_xfer, wr_last, rd_last;
    logic          rd_bit;

    assign ready_out = !full_q[wr_bank_q];
    assign valid_out = full_q[rd_bank_q];
    assign wr_xfer   = valid_in && ready_out;
    assign rd_xfer   = valid_out && ready_in;
    assign wr_last   = wr_xfer && (wr_cnt_q == LAST_IDX);
    assign rd_last   = rd_xfer && (rd_cnt_q == LAST_IDX);
    assign data_out  = valid_out & rd_bit;

    // A finishing write targets an empty bank and a finishing read a full one,
    // so the set and clear below never hit the same flag.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        if (wr_xfer) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_cnt_d          = '0;
            wr_bank_d         = !wr_bank_q;
        end
        if (rd_xfer) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_cnt_d          = '0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    deint_pingpong_buf #(
        .NCBPS (NCBPS),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (wr_xfer),
        .wbank_i (wr_bank_q),
        .waddr_i (addr_tbl[wr_cnt_q]),
        .wdata_i (data_in),
        .rbank_i (rd_bank_q),
        .raddr_i (rd_cnt_q),
        .rdata_o (rd_bit)
    );

`ifdef DEINT_SOB_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    assign sob_out   = valid_out && (rd_cnt_q == '0);
    assign blk_cnt   = blk_cnt_q;
    assign blk_cnt_d = rd_last ? blk_cnt_q + 16'd1 : blk_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_deinterleaver_top.sv
// Self-checking bench for deinterleaver_top: golden vectors, back-to-back,
// backpressure, address map, mid-block reset and randomized handshakes.
module tb_deinterleaver_top;

    localparam int N = 192;
    localparam logic [N-1:0] GOLD_IN  = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
    localparam logic [N-1:0] GOLD_OUT = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

    logic clk = 1'b0;
    logic reset, data_in, valid_in, ready_in;
    logic ready_out, data_out, valid_out;
`ifdef DEINT_SOB_EN
    logic        sob_out;
    logic [15:0] blk_cnt;
    bit          sob_q[$];
`endif

    int n_pass = 0;
    int n_total = 0;
    int n_acc = 0;
    bit in_q[$];
    bit out_q[$];
    bit rin = 1'b0;
    bit rnd_valid = 1'b0;
    bit rnd_ready = 1'b0;

    always #5 clk = ~clk;

    deinterleaver_top dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
`ifdef DEINT_SOB_EN
        .sob_out   (sob_out),
        .blk_cnt   (blk_cnt),
`endif
        .ready_in  (ready_in)
    );

    // Reference: received bit j belongs at FEC position 16*(j mod 12) + j/12.
    function automatic logic [N-1:0] model_deint(input logic [N-1:0] blk);
        logic [N-1:0] o;
        int k;
        o = '0;
        for (int j = 0; j < N; j++) begin
            k = 16 * (j % 12) + j / 12;
            o[N-1-k] = blk[N-1-j];
        end
        return o;
    endfunction

    function automatic logic [N-1:0] out_block(input int b);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            if (b * N + i < out_q.size()) v[N-1-i] = out_q[b*N+i];
            else v[N-1-i] = 1'bx;
        end
        return v;
    endfunction

    task automatic push_block(input logic [N-1:0] blk);
        for (int j = 0; j < N; j++) in_q.push_back(blk[N-1-j]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        data_in = 1'b0;
        ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        in_q.delete();
        out_q.delete();
`ifdef DEINT_SOB_EN
        sob_q.delete();
`endif
        n_acc = 0;
        rin = 1'b0;
        rnd_valid = 1'b0;
        rnd_ready = 1'b0;
    endtask

    // One clock: drive inputs, log the transfers the coming edge will make.
    task automatic step();
        valid_in = (in_q.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
        data_in  = valid_in ? in_q[0] : 1'b0;
        ready_in = rnd_ready ? ($urandom_range(0, 2) != 0) : rin;
        if (valid_in && ready_out) begin
            void'(in_q.pop_front());
            n_acc++;
        end
        if (valid_out && ready_in) begin
            out_q.push_back(data_out);
`ifdef DEINT_SOB_EN
            sob_q.push_back(sob_out);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_out(input int nbits, input int budget);
        for (int c = 0; c < budget && out_q.size() < nbits; c++) step();
        n_total++;
        if (out_q.size() !== nbits) $display("FAIL out_count got %0d exp %0d", out_q.size(), nbits);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (ready_out !== 1'b1) $display("FAIL reset_ready_out got %b exp 1", ready_out);
        else n_pass++;
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL reset_valid_out got %b exp 0", valid_out);
        else n_pass++;
        n_total++;
        if (data_out !== 1'b0) $display("FAIL reset_data_out got %b exp 0", data_out);
        else n_pass++;
`ifdef DEINT_SOB_EN
        n_total++;
        if (sob_out !== 1'b0 || blk_cnt !== 16'd0)
            $display("FAIL reset_sob got sob=%b cnt=%0d exp 0/0", sob_out, blk_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_golden();
        int early;
        bit last;
        do_reset();
        push_block(GOLD_IN);
        rin = 1'b1;
        early = 0;
        for (int c = 0; c < 600 && out_q.size() < N; c++) begin
            last = (in_q.size() == 1) && ready_out;
            if (in_q.size() > 0 && valid_out) early++;
            step();
            if (last) begin
                n_total++;
                if (valid_out !== 1'b1) $display("FAIL golden_latency got valid_out=%b exp 1", valid_out);
                else n_pass++;
            end
        end
        n_total++;
        if (early !== 0) $display("FAIL golden_early_valid got %0d exp 0", early);
        else n_pass++;
        n_total++;
        if (out_q.size() !== N) $display("FAIL golden_count got %0d exp %0d", out_q.size(), N);
        else n_pass++;
        n_total++;
        if (out_block(0) !== GOLD_OUT) $display("FAIL golden_block got %h exp %h", out_block(0), GOLD_OUT);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int drops, bubbles;
        bit seen;
        do_reset();
        for (int b = 0; b < 5; b++) push_block(GOLD_IN);
        rin = 1'b1;
        drops = 0;
        bubbles = 0;
        seen = 1'b0;
        for (int c = 0; c < 2000 && out_q.size() < 5 * N; c++) begin
            if (in_q.size() > 0 && !ready_out) drops++;
            if (seen && !valid_out) bubbles++;
            if (valid_out) seen = 1'b1;
            step();
        end
        n_total++;
        if (drops !== 0) $display("FAIL b2b_ready_drops got %0d exp 0", drops);
        else n_pass++;
        n_total++;
        if (bubbles !== 0) $display("FAIL b2b_bubbles got %0d exp 0", bubbles);
        else n_pass++;
        for (int b = 0; b < 5; b++) begin
            n_total++;
            if (out_block(b) !== GOLD_OUT) $display("FAIL b2b_block%0d got %h exp %h", b, out_block(b), GOLD_OUT);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int b = 0; b < 3; b++) push_block(GOLD_IN);
        rin = 1'b0;
        for (int c = 0; c < 500 && ready_out; c++) step();
        n_total++;
        if (n_acc !== 2 * N) $display("FAIL bp_stall_point got %0d exp %0d", n_acc, 2 * N);
        else n_pass++;
        n_total++;
        if (valid_out !== 1'b1) $display("FAIL bp_valid got %b exp 1", valid_out);
        else n_pass++;
        rin = 1'b1;
        for (int c = 0; c < 400 && !ready_out; c++) step();
        n_total++;
        if (out_q.size() !== N) $display("FAIL bp_release got %0d reads exp %0d", out_q.size(), N);
        else n_pass++;
        run_until_out(3 * N, 1000);
        for (int b = 0; b < 3; b++) begin
            n_total++;
            if (out_block(b) !== GOLD_OUT) $display("FAIL bp_block%0d got %h exp %h", b, out_block(b), GOLD_OUT);
            else n_pass++;
        end
    endtask

    task automatic test_addr_map();
        int js[4] = '{0, 1, 12, 191};
        int ks[4] = '{0, 16, 1, 191};
        logic [N-1:0] blk;
        int ones, pos;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            blk = '0;
            blk[N-1-js[i]] = 1'b1;
            push_block(blk);
            rin = 1'b1;
            for (int c = 0; c < 600 && out_q.size() < N; c++) step();
            ones = 0;
            pos = -1;
            foreach (out_q[p]) if (out_q[p]) begin ones++; pos = p; end
            n_total++;
            if (ones !== 1 || pos !== ks[i])
                $display("FAIL addr_map_j%0d got pos %0d (ones %0d) exp pos %0d", js[i], pos, ones, ks[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_block(GOLD_IN);
        rin = 1'b1;
        for (int c = 0; c < 200 && n_acc < 100; c++) step();
        reset = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_q.delete();
        out_q.delete();
        n_acc = 0;
        n_total++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1)
            $display("FAIL midrst_flags got valid=%b ready=%b exp 0/1", valid_out, ready_out);
        else n_pass++;
        push_block(GOLD_IN);
        run_until_out(N, 600);
        n_total++;
        if (out_block(0) !== GOLD_OUT) $display("FAIL midrst_block got %h exp %h", out_block(0), GOLD_OUT);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] blks [4];
        do_reset();
        for (int b = 0; b < 4; b++) begin
            blks[b] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            push_block(blks[b]);
        end
        rnd_valid = 1'b1;
        rnd_ready = 1'b1;
        run_until_out(4 * N, 6000);
        for (int b = 0; b < 4; b++) begin
            n_total++;
            if (out_block(b) !== model_deint(blks[b]))
                $display("FAIL random_block%0d got %h exp %h", b, out_block(b), model_deint(blks[b]));
            else n_pass++;
        end
        rnd_valid = 1'b0;
        rnd_ready = 1'b0;
    endtask

`ifdef DEINT_SOB_EN
    task automatic test_sob();
        int bad;
        do_reset();
        for (int b = 0; b < 3; b++) push_block(GOLD_IN);
        rin = 1'b1;
        run_until_out(3 * N, 1500);
        bad = 0;
        foreach (sob_q[p]) if (sob_q[p] !== ((p % N) == 0)) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL sob_positions got %0d wrong bits exp 0", bad);
        else n_pass++;
        n_total++;
        if (blk_cnt !== 16'd3) $display("FAIL sob_blk_cnt got %0d exp 3", blk_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_golden();
        test_back_to_back();
        test_backpressure();
        test_addr_map();
        test_mid_reset();
        test_random();
`ifdef DEINT_SOB_EN
        test_sob();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
